// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin Wishbone arbiter (one stb/ack per grant); optional bus-timeout watchdog via WB_ARB_TMO_EN.
// Ports: clk, rst_n (async active-low); m0_*/m1_* master ports (adr_i, dat_i, dat_o, we_i, stb_i, ack_o);
//        s_* slave port (adr_o, dat_o, dat_i, we_o, stb_o, ack_i); owner_o current/last grantee, busy_o transfer in progress,
//        tmo_o sticky timeout flag (tied 0 unless WB_ARB_TMO_EN is defined).
module wb_arbiter2 #(
  parameter int AW = 15,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  input  logic          m0_we_i,
  input  logic          m0_stb_i,
  output logic          m0_ack_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  input  logic          m1_we_i,
  input  logic          m1_stb_i,
  output logic          m1_ack_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  output logic          s_we_o,
  output logic          s_stb_o,
  input  logic          s_ack_i,
  output logic          owner_o,
  output logic          busy_o,
  output logic          tmo_o
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [15:0] TMO_M1 = 16'(TIMEOUT - 1);
  state_t state;
  logic owner, gstb, tmo_hit, ack, rd;
  // owner doubles as last_owner: it is loaded with the winner at grant time and simply kept afterwards
  assign busy_o   = state == GRANT;
  assign owner_o  = owner;
  assign gstb     = busy_o & (owner ? m1_stb_i : m0_stb_i);
  assign s_stb_o  = gstb & ~tmo_hit;
  assign s_adr_o  = busy_o ? (owner ? m1_adr_i : m0_adr_i) : '0;
  assign s_dat_o  = busy_o ? (owner ? m1_dat_i : m0_dat_i) : '0;
  assign s_we_o   = busy_o & (owner ? m1_we_i : m0_we_i);
  assign ack      = busy_o & (s_ack_i | tmo_hit);
  assign rd       = busy_o & s_ack_i;
  assign m0_ack_o = ack & ~owner;
  assign m1_ack_o = ack & owner;
  assign m0_dat_o = (rd & ~owner) ? s_dat_i : '0;
  assign m1_dat_o = (rd & owner) ? s_dat_i : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b1;
    end else if (state == IDLE) begin
      if (m0_stb_i | m1_stb_i) begin
        state <= GRANT;
        owner <= (m0_stb_i & m1_stb_i) ? ~owner : m1_stb_i;
      end
    end else if (s_ack_i | ~gstb | tmo_hit) state <= IDLE;
`ifdef WB_ARB_TMO_EN
  logic [15:0] cnt;
  logic tmo_q;
  // a dropped strobe is an abort, not a stall, so only a live strobe can time out
  assign tmo_hit = gstb & ~s_ack_i & (cnt == TMO_M1);
  assign tmo_o   = tmo_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt <= busy_o ? cnt + 16'd1 : '0;
      if (tmo_hit) tmo_q <= 1'b1;
    end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_M1;
  assign tmo_hit    = 1'b0;
  assign tmo_o      = 1'b0;
`endif
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed plus randomized bench for wb_arbiter2 against a cycle-level behavioural model.
module tb_wb_arbiter2;
  localparam int TO = 8;
`ifdef WB_ARB_TMO_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [14:0] madr [2];
  logic [31:0] mdat [2];
  logic mwe [2], mstb [2];
  logic [31:0] m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [14:0] s_adr_o;
  logic m0_ack_o, m1_ack_o, s_we_o, s_stb_o, s_ack_i, owner_o, busy_o, tmo_o;
  int vectors = 0, miscompares = 0;
  bit mb = 1'b0, mg = 1'b1, mlast = 1'b1, mtmo = 1'b0;
  int mcnt = 0;
  bit acked [2];

  wb_arbiter2 #(.AW(15), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_dat_o(m0_dat_o), .m0_we_i(mwe[0]), .m0_stb_i(mstb[0]), .m0_ack_o(m0_ack_o),
    .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_dat_o(m1_dat_o), .m1_we_i(mwe[1]), .m1_stb_i(mstb[1]), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i),
    .owner_o(owner_o), .busy_o(busy_o), .tmo_o(tmo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input int i, input logic [14:0] a, input logic [31:0] d, input logic w);
    madr[i] = a; mdat[i] = d; mwe[i] = w; mstb[i] = 1'b1;
  endtask

  // Called with inputs already driven, just after a falling edge; checks, then advances one clock.
  task automatic tick();
    bit gs, tf;
    bit ea [2];
    logic [31:0] ed [2];
    #1;
    if (!rst_n) begin mb = 1'b0; mlast = 1'b1; mtmo = 1'b0; mcnt = 0; end
    gs = mb && mstb[mg];
    tf = TMO && gs && !s_ack_i && mcnt == TO - 1;
    for (int i = 0; i < 2; i++) begin
      ea[i] = mb && int'(mg) == i && (s_ack_i || tf);
      ed[i] = (ea[i] && s_ack_i) ? s_dat_i : 32'h0;
    end
    chk("busy", 64'(busy_o), 64'(mb));
    chk("owner", 64'(owner_o), 64'(mb ? mg : mlast));
    chk("s_stb", 64'(s_stb_o), 64'(gs && !tf));
    chk("s_adr", 64'(s_adr_o), mb ? 64'(madr[mg]) : 64'h0);
    chk("s_dat", 64'(s_dat_o), mb ? 64'(mdat[mg]) : 64'h0);
    chk("s_we", 64'(s_we_o), mb ? 64'(mwe[mg]) : 64'h0);
    chk("m0_ack", 64'(m0_ack_o), 64'(ea[0]));
    chk("m1_ack", 64'(m1_ack_o), 64'(ea[1]));
    chk("m0_dat", 64'(m0_dat_o), 64'(ed[0]));
    chk("m1_dat", 64'(m1_dat_o), 64'(ed[1]));
    chk("tmo", 64'(tmo_o), 64'(mtmo));
    @(posedge clk);
    if (rst_n) begin
      if (!mb) begin
        if (mstb[0] || mstb[1]) begin
          mb = 1'b1;
          mg = (mstb[0] && mstb[1]) ? !mlast : mstb[1];
          mcnt = 0;
        end
      end else if (s_ack_i || !mstb[mg] || tf) begin
        mb = 1'b0;
        mlast = mg;
      end else mcnt++;
      if (tf) mtmo = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      acked[i] = ea[i];
      if (ea[i]) mstb[i] = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin madr[i] = '0; mdat[i] = '0; mwe[i] = 1'b0; mstb[i] = 1'b0; end
    s_ack_i = 1'b0; s_dat_i = 32'h0;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // 1: m0 read, zero-wait slave
    req(0, 15'h0004, 32'h0, 1'b0);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
    tick();
    s_ack_i = 1'b0;
    tick();
    // 2: both masters re-request continuously, zero-wait slave -> alternating grants
    s_ack_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      s_dat_i = $urandom;
      if (!mstb[0]) req(0, 15'(k), $urandom, 1'b0);
      if (!mstb[1]) req(1, 15'(k + 100), $urandom, 1'b1);
      tick();
    end
    mstb[0] = 1'b0; mstb[1] = 1'b0; s_ack_i = 1'b0;
    tick();
    tick();
    // 3: m1 write with 3 wait states while m0 is also requesting
    req(1, 15'h7FFF, 32'h12345678, 1'b1);
    tick();
    req(0, 15'h0011, 32'hA5A5A5A5, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    s_ack_i = 1'b1;
    tick();
    tick();
    tick();
    s_ack_i = 1'b0;
    tick();
    // 4: reset mid-GRANT, then a tie goes to m0
    req(0, 15'h0123, 32'h1, 1'b1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mstb[0] = 1'b0;
    tick();
    req(0, 15'h0A0A, 32'h2, 1'b0);
    req(1, 15'h0B0B, 32'h3, 1'b0);
    tick();
    s_ack_i = 1'b1;
    tick();
    tick();
    tick();
    s_ack_i = 1'b0;
    tick();
    // 6: m0 aborts while m1 waits; m1 is granted next
    req(0, 15'h0042, 32'h4, 1'b0);
    tick();
    req(1, 15'h0043, 32'h5, 1'b1);
    tick();
    mstb[0] = 1'b0;
    tick();
    tick();
    s_ack_i = 1'b1;
    tick();
    s_ack_i = 1'b0;
    tick();
`ifdef WB_ARB_TMO_EN
    // 5: slave never acks -> forced termination, then a normal transfer
    req(0, 15'h0077, 32'h6, 1'b0);
    for (int k = 0; k < 12; k++) tick();
    req(0, 15'h0078, 32'h7, 1'b0);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hCAFEF00D;
    tick();
    s_ack_i = 1'b0;
    tick();
`endif
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!mstb[i] && !acked[i] && $urandom_range(2) == 0) req(i, 15'($urandom), $urandom, 1'($urandom));
        else if (mstb[i] && $urandom_range(39) == 0) mstb[i] = 1'b0;
      end
      s_ack_i = $urandom_range(2) == 0;
      s_dat_i = $urandom;
      if (k == 1500) #2 rst_n = 1'b0;
      if (k == 1502) rst_n = 1'b1;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
